// File: rtl/regfile_port_arbiter.sv
// Shares the register file's single write port between core writeback, a debug
// write channel and a clear sequencer that zeroes x1..x31.
module regfile_port_arbiter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_we,
  input  logic [4:0]       core_rd,
  input  logic [WIDTH-1:0] core_data,
  input  logic             dbg_valid,
  input  logic [4:0]       dbg_rd,
  input  logic [WIDTH-1:0] dbg_data,
  output logic             dbg_ready,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             core_stall,
  output logic             rf_write_enable,
  output logic [4:0]       rf_dest,
  output logic [WIDTH-1:0] rf_data
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q, state_d;
  logic [4:0]      clr_idx_q, clr_idx_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            clr_done_q, clr_done_d;

  logic core_hit;
  logic force_dbg;
  logic dbg_drives;

  assign core_hit  = core_we && (core_rd != 5'd0);
  assign force_dbg = (starve_cnt_q == CntMax) && dbg_valid;

  // Port selection; reset forces every output low regardless of state.
  always_comb begin
    dbg_ready       = 1'b0;
    core_stall      = 1'b0;
    rf_write_enable = 1'b0;
    rf_dest         = 5'd0;
    rf_data         = '0;
    dbg_drives      = 1'b0;
    if (!reset) begin
      case (state_q)
        StIdle: begin
          if (force_dbg) begin
            core_stall = 1'b1;
            dbg_ready  = 1'b1;
            dbg_drives = 1'b1;
          end else if (core_hit) begin
            rf_write_enable = 1'b1;
            rf_dest         = core_rd;
            rf_data         = core_data;
          end else begin
            dbg_ready  = 1'b1;
            dbg_drives = dbg_valid;
          end
          // A debug write to x0 completes the handshake without touching the file.
          if (dbg_drives && (dbg_rd != 5'd0)) begin
            rf_write_enable = 1'b1;
            rf_dest         = dbg_rd;
            rf_data         = dbg_data;
          end
        end
        StClear: begin
          rf_write_enable = 1'b1;
          rf_dest         = clr_idx_q;
          core_stall      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign clr_busy = (state_q == StClear) && !reset;
  assign clr_done = clr_done_q && !reset;

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    starve_cnt_d = starve_cnt_q;
    clr_done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!dbg_valid || dbg_ready) begin
          starve_cnt_d = '0;
        end else if (starve_cnt_q != CntMax) begin
          starve_cnt_d = starve_cnt_q + CntW'(1);
        end
        if (clr_start) begin
          state_d   = StClear;
          clr_idx_d = 5'd1;
        end
      end
      StClear: begin
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) begin
          state_d    = StIdle;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      clr_idx_q    <= 5'd0;
      starve_cnt_q <= '0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      starve_cnt_q <= starve_cnt_d;
      clr_done_q   <= clr_done_d;
    end
  end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Owns the register file's single write port and shares it between three sources: core writeback, a debug write channel with valid/ready handshake, and a hardware clear sequencer that zeroes x1..x31. It sits between the core's writeback stage and the register file. It drives the register file's write_enable, Destination_select and DATA inputs, and returns a stall to the core when the core must yield the port.

## Interface
- WIDTH, 32, data width; matches the register file.
- STARVE_LIMIT, 8, number of refused debug cycles before the core is force-stalled; must be ≥1.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- core_we  in  1  core writeback enable.
- core_rd  in  5  core destination register.
- core_data  in  WIDTH  core writeback data.
- dbg_valid  in  1  debug write request.
- dbg_rd  in  5  debug destination register.
- dbg_data  in  WIDTH  debug write data.
- dbg_ready  out  1  debug write accepted this cycle.
- clr_start  in  1  start clear sequence (level sampled).
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- core_stall  out  1  core must hold PC and discard its writeback this cycle.
- rf_write_enable  out  1  to register file write_enable.
- rf_dest  out  5  to register file Destination_select.
- rf_data  out  WIDTH  to register file DATA.

## Operation
- The state machine has two states: IDLE and CLEAR. The registered state is: state, clr_idx (5 bits), starve_cnt ($clog2(STARVE_LIMIT+1) bits), and clr_done.
- core_hit = core_we && core_rd != 0.
- force = (starve_cnt == STARVE_LIMIT) && dbg_valid.
- IDLE port selection (combinational):
  - If force: core_stall=1, dbg_ready=1, the debug source drives the port, and core_we is ignored.
  - Else if core_hit: the core drives the port, dbg_ready=0.
  - Else: dbg_ready=1; the debug source drives the port when dbg_valid is high.
- Debug transfer occurs when dbg_valid && dbg_ready. rf_write_enable = (dbg_rd != 0). A debug write to x0 completes the handshake but produces no write.
- Core write: rf_write_enable=1 only when core_hit. A core write to x0 never asserts rf_write_enable.
- starve_cnt:
  - Cleared on any debug handshake and whenever dbg_valid=0.
  - Incremented (saturating at STARVE_LIMIT) when dbg_valid && !dbg_ready.
- IDLE→CLEAR: transition when clr_start=1 at a clock edge in IDLE; clr_idx loads 1. Normal arbitration still applies during the cycle clr_start is sampled.
- CLEAR state:
  - Outputs: rf_write_enable=1, rf_dest=clr_idx, rf_data=0, core_stall=1, dbg_ready=0, clr_busy=1.
  - clr_idx increments each cycle. The cycle with clr_idx=31 is the last; the next state is IDLE and clr_done is set for one cycle.
  - clr_start is ignored while in CLEAR. starve_cnt holds its value.
- When no source writes: rf_write_enable=0, rf_dest=0, rf_data=0.

## Timing
- Port outputs, dbg_ready and core_stall are combinational from state and inputs. A granted write lands at the register file's next active write edge in the same cycle. Latency through the arbiter is zero cycles.
- When reset=1, regardless of state:
  - state=IDLE, clr_idx=0, starve_cnt=0, clr_done=0.
  - All outputs are forced to 0: rf_write_enable, dbg_ready, core_stall, clr_busy.
- Reset during CLEAR aborts the sequence. Registers already cleared stay cleared, no clr_done pulse is produced, and the first post-reset cycle is IDLE.
- A clear takes exactly 31 busy cycles. clr_done is asserted on cycle 32 after sampling, concurrent with IDLE arbitration.
- Worst-case debug wait under continuous core writes is STARVE_LIMIT refused cycles, then a grant on the next cycle.
- The debug requester must hold dbg_rd and dbg_data stable while dbg_valid is high and dbg_ready is low.

## Test plan
- Reset held 3 cycles with all inputs active -> every output is 0; after release with core_we=1, core_rd=5, core_data=0xDEADBEEF -> rf_write_enable=1, rf_dest=5, rf_data=0xDEADBEEF, core_stall=0.
- core_we=0 and dbg_valid=1, dbg_rd=7, dbg_data=0x1234 -> dbg_ready=1 in the same cycle and the port writes x7=0x1234; repeat with dbg_rd=0 -> handshake completes, rf_write_enable=0.
- STARVE_LIMIT=8, core writing x3 every cycle, dbg_valid held with dbg_rd=9 -> dbg_ready=0 for 8 cycles; on the 9th cycle core_stall=1, dbg_ready=1, rf_dest=9; the next cycle the core owns the port again.
- clr_start pulsed for 1 cycle -> 31 cycles with clr_busy=1 and core_stall=1, writing rf_dest 1..31 with rf_data=0; the following cycle has clr_done=1 for one cycle; a dbg_valid held throughout is granted in that clr_done cycle.
- Reset asserted at the 10th CLEAR cycle -> next cycle is IDLE with clr_busy=0, no clr_done pulse, and a core write to x4 is granted.
- core_we=1 with core_rd=0 and dbg_valid=1 -> dbg_ready=1 and the debug write wins; core_stall=0.
